// File: rtl/mux_arbiter.sv
// Round-robin arbiter for an 8:1 shared mux: one owner at a time, bounded hold,
// and one idle turnaround cycle between owners.
module mux_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] select,
    output logic       valid,
    output logic       expire,
    output logic       fsm_state
);

    // Handshake: req[i] is a level request held by requester i. A grant is
    // taken one cycle after req is seen in IDLE; the owner keeps it while its
    // req stays high, up to MAX_HOLD cycles; dropping req ends ownership.

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] hcnt;
    logic [2:0] winner;
    logic [2:0] idx;
    logic       found;

    // First requester at or after ptr, wrapping 7 -> 0.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign fsm_state = (state == GRANT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            grant  <= 8'h00;
            select <= 3'd0;
            valid  <= 1'b0;
            expire <= 1'b0;
            ptr    <= 3'd0;
            hcnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    expire <= 1'b0;
                    if (found) begin
                        state  <= GRANT;
                        select <= winner;
                        grant  <= 8'h01 << winner;
                        valid  <= 1'b1;
                        hcnt   <= 8'd0;
                    end
                end
                GRANT: begin
                    // Release wins over the hold limit when both happen together.
                    if (!req[select]) begin
                        state  <= IDLE;
                        grant  <= 8'h00;
                        valid  <= 1'b0;
                        expire <= 1'b0;
                        ptr    <= select + 3'd1;
                    end else if (hcnt == HOLD_LAST) begin
                        state  <= IDLE;
                        grant  <= 8'h00;
                        valid  <= 1'b0;
                        expire <= 1'b1;
                        ptr    <= select + 3'd1;
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 8'h00;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, meaning the maximum consecutive GRANT cycles per ownership; legal range 2..255.
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, meaning the reset: asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 8, meaning per-requester level request; bit i is requester i.
REQ-005 The block SHALL have port grant, output, 8, meaning the one-hot current owner; all-zero when no owner.
REQ-006 The block SHALL have port select, output, 3, meaning the binary index of the current or last owner; drives the shared 8:1 mux select.
REQ-007 The block SHALL have port valid, output, 1, meaning the mux output belongs to the owner in grant.
REQ-008 The block SHALL have port expire, output, 1, meaning a one-cycle pulse: the last ownership was force-ended by the hold limit.

Function
REQ-009 All outputs SHALL be registered; no combinational path from req to any output.
REQ-010 The FSM SHALL have exactly two states: IDLE (valid=0, grant=0) and GRANT (valid=1, grant=one-hot of select).
REQ-011 Internal state SHALL be: rotation pointer ptr (3 bits) and hold counter hcnt (8 bits).
REQ-012 The winner SHALL be the first i with req[i]=1, searching ptr, ptr+1, ... mod 8 (wrapping 7 -> 0).
REQ-013 IDLE with req != 0 at an edge: go to GRANT; select = winner; grant = 1<<winner; hcnt = 0. Latency is 1 cycle from request to grant.
REQ-014 IDLE with req = 0: stay in IDLE; select holds its previous value.
REQ-015 GRANT with req[select]=1 and hcnt < MAX_HOLD-1: stay in GRANT; hcnt increments by 1.
REQ-016 GRANT with req[select]=0 (release): go to IDLE; ptr = (select+1) mod 8; expire = 0.
REQ-017 GRANT with req[select]=1 and hcnt = MAX_HOLD-1 (hold limit): go to IDLE; ptr = (select+1) mod 8; expire = 1 for exactly the first IDLE cycle.
REQ-018 If release and hold limit occur in the same cycle, the block SHALL treat it as a release (expire = 0).
REQ-019 valid SHALL be high for at most MAX_HOLD consecutive cycles.
REQ-020 Every ownership end SHALL be followed by exactly one IDLE turnaround cycle (valid=0) before the next grant, including back-to-back requests.
REQ-021 Changes on req bits other than req[select] during GRANT SHALL have no effect until the next IDLE cycle.
REQ-022 select SHALL change only on IDLE->GRANT transitions; it stays stable through GRANT and the following IDLE.
REQ-023 grant SHALL never have more than one bit set.
REQ-024 A requester whose ownership was ended by the hold limit and which keeps req high SHALL be served after all other active requesters, as given by the rotation order.

Reset
REQ-025 reset_n=0 SHALL immediately, without waiting for clk, force: state=IDLE, grant=8'h00, select=3'd0, valid=0, expire=0, ptr=0, hcnt=0.
REQ-026 Reset asserted mid-GRANT SHALL drop valid and grant in the same cycle; the ownership is lost and no expire pulse is generated.
REQ-027 After reset_n rises, the first grant SHALL follow REQ-013 with ptr=0.

Verification (MAX_HOLD=16)
REQ-028 Reset check: assert reset_n=0 between edges while in GRANT -> grant=00, valid=0, select=0 immediately, before the next edge.
REQ-029 Single request: req=8'h20 -> at the next edge grant=8'h20, select=5, valid=1; drop req -> at the next edge valid=0, grant=00, select stays 5.
REQ-030 Rotation: ptr=0, req=8'h81; owner 0 releases and immediately re-requests -> one IDLE cycle, then grant=8'h80 (select=7); after 7 releases -> grant=8'h01.
REQ-031 Wrap: owner 6 releases (ptr=7), req=8'h03 -> grant=8'h01, not 8'h02.
REQ-032 Hold limit: req=8'h08 held constantly -> valid high for exactly 16 cycles; then 1 IDLE cycle with expire=1; then grant=8'h08 again. With req=8'h18 held constantly, the grant after expiry SHALL be 8'h10.
REQ-033 Simultaneous events: drop req[select] on the cycle where hcnt=15 -> IDLE with expire=0.
